// File: rtl/md_defs.sv
// Shared definitions for the HI/LO multiply/divide scheduler:
// op codes, FSM states and the long-op classifier.
package md_defs;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

   // True for ops that occupy the unit for several cycles.
   function automatic logic is_md_long(input logic [2:0] op);
      return (op == OP_MULT)  || (op == OP_MULTU) ||
             (op == OP_DIV)   || (op == OP_DIVU);
   endfunction

   // True for the divide ops (select the longer latency).
   function automatic logic is_md_div(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/md_scheduler_md_latency_counter.sv
// Loadable down-counter that times the busy window of the
// multiply/divide unit; stops at zero.
module md_latency_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic [W-1:0] value_o,
   output logic         zero_o
);

   logic [W-1:0] value_q;
   logic [W-1:0] value_d;

   // Next count: load wins over decrement; never wraps below zero.
   always_comb begin
      value_d = value_q;
      if (load_i) begin
         value_d = load_val_i;
      end else if (dec_i && (value_q != '0)) begin
         value_d = value_q - W'(1);
      end
   end

   // Count register, cleared by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value_o = value_q;
   assign zero_o  = (value_q == '0);

endmodule

// File: rtl/md_scheduler.sv
// HI/LO multiply/divide scheduler: fixed-latency busy window,
// D-stage stall generation and HI/LO commit.
module md_scheduler
   import md_defs::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        d_is_md,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   md_state_e   state_q;
   logic [2:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;

   logic          long_start;
   logic          accept;
   logic          run;
   logic          commit;
   logic [CW-1:0] cnt;
   logic          cnt_zero;
   logic [CW-1:0] lat;

   logic          res_we;
   logic [31:0]   res_hi;
   logic [31:0]   res_lo;

   logic signed [63:0] smul;
   logic        [63:0] umul;
   logic signed [31:0] sq;
   logic signed [31:0] sr;

   assign long_start = start & is_md_long(op);
   assign run        = (state_q == ST_RUN);
   assign accept     = (state_q == ST_IDLE) & long_start;
   assign lat        = is_md_div(op) ? CW'(DIV_CYCLES)
                                     : CW'(MULT_CYCLES);
   // The committing edge is the one that takes the count 1 -> 0.
   assign commit     = run & (cnt == CW'(1));

   md_latency_counter #(
      .W (CW)
   ) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (accept),
      .load_val_i (lat),
      .dec_i      (run & ~cnt_zero),
      .value_o    (cnt),
      .zero_o     (cnt_zero)
   );

   // Behavioural result from the latched operands.
   always_comb begin
      res_we = 1'b0;
      res_hi = hi_q;
      res_lo = lo_q;
      smul   = $signed({{32{a_q[31]}}, a_q}) *
               $signed({{32{b_q[31]}}, b_q});
      umul   = {32'b0, a_q} * {32'b0, b_q};
      sq     = '0;
      sr     = '0;
      case (op_q)
         OP_MULT: begin
            res_we = 1'b1;
            res_hi = smul[63:32];
            res_lo = smul[31:0];
         end
         OP_MULTU: begin
            res_we = 1'b1;
            res_hi = umul[63:32];
            res_lo = umul[31:0];
         end
         OP_DIV: begin
            if (b_q != '0) begin
               res_we = 1'b1;
               // The one overflowing quotient is pinned explicitly.
               if ((a_q == 32'h8000_0000) &&
                   (b_q == 32'hFFFF_FFFF)) begin
                  res_hi = '0;
                  res_lo = 32'h8000_0000;
               end else begin
                  sq     = $signed(a_q) / $signed(b_q);
                  sr     = $signed(a_q) % $signed(b_q);
                  res_hi = sr;
                  res_lo = sq;
               end
            end
         end
         OP_DIVU: begin
            if (b_q != '0) begin
               res_we = 1'b1;
               res_hi = a_q % b_q;
               res_lo = a_q / b_q;
            end
         end
         default: begin
            res_we = 1'b0;
         end
      endcase
   end

   // Scheduler FSM with registered HI/LO and done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (accept) begin
                  op_q    <= op;
                  a_q     <= rs_val;
                  b_q     <= rt_val;
                  state_q <= ST_RUN;
                  done_q  <= (lat == CW'(1));
               end else if (start && (op == OP_MTHI)) begin
                  hi_q <= rs_val;
               end else if (start && (op == OP_MTLO)) begin
                  lo_q <= rs_val;
               end
            end
            ST_RUN: begin
               done_q <= (cnt == CW'(2));
               if (commit) begin
                  if (res_we) begin
                     hi_q <= res_hi;
                     lo_q <= res_lo;
                  end
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy  = run;
   assign stall = d_is_md & (run | long_start);
   assign done  = done_q;
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: vector table,
// hand-written corner sequences and randomized ops vs a model.
module tb_md_scheduler;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        d_is_md;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int passed = 0;

   logic [31:0] m_hi;
   logic [31:0] m_lo;

   md_scheduler #(
      .MULT_CYCLES (MC),
      .DIV_CYCLES  (DC)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .d_is_md (d_is_md),
      .busy    (busy),
      .stall   (stall),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] ehi;
      logic [31:0] elo;
      string       nm;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference: architectural HI/LO result from plain arithmetic.
   function automatic logic [63:0] ref_md(input logic [2:0] o,
      input logic [31:0] a, input logic [31:0] b,
      input logic [63:0] cur);
      longint x, y, q, r;
      longint unsigned ux, uy, uq, ur;
      ref_md = cur;
      case (o)
         3'd0: begin
            x = longint'($signed(a));
            y = longint'($signed(b));
            q = x * y;
            ref_md = q;
         end
         3'd1: begin
            ux = {32'b0, a};
            uy = {32'b0, b};
            uq = ux * uy;
            ref_md = uq;
         end
         3'd2: if (b != 0) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
            q = x / y;
            r = x % y;
            ref_md = {r[31:0], q[31:0]};
         end
         3'd3: if (b != 0) begin
            ux = {32'b0, a};
            uy = {32'b0, b};
            uq = ux / uy;
            ur = ux % uy;
            ref_md = {ur[31:0], uq[31:0]};
         end
         3'd4: ref_md = {a, cur[31:0]};
         3'd5: ref_md = {cur[63:32], a};
         default: ref_md = cur;
      endcase
   endfunction

   function automatic int lat_of(input logic [2:0] o);
      if (o == 3'd0 || o == 3'd1) return MC;
      if (o == 3'd2 || o == 3'd3) return DC;
      return 0;
   endfunction

   // Issue one op and check busy window, done pulse and HI/LO.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] ehi,
      input logic [31:0] elo, input string nm);
      int n, bc, dc, dp;
      logic [31:0] hi1, lo1;
      n = lat_of(o);
      bc = 0; dc = 0; dp = -1;
      hi1 = '0; lo1 = '0;
      @(negedge clk);
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      rs_val = $urandom;
      rt_val = $urandom;
      for (int i = 1; i <= n + 3; i++) begin
         @(negedge clk);
         if (i == 1) begin
            hi1 = hi;
            lo1 = lo;
         end
         if (busy) bc++;
         if (done) begin
            dc++;
            dp = i;
         end
      end
      check({nm, " busy_cycles"}, bc, n);
      check({nm, " done_count"}, dc, (n > 0) ? 1 : 0);
      if (n > 0) check({nm, " done_pos"}, dp, n);
      else begin
         check({nm, " hi_after_1"}, hi1, ehi);
         check({nm, " lo_after_1"}, lo1, elo);
      end
      check({nm, " hi"}, hi, ehi);
      check({nm, " lo"}, lo, elo);
      m_hi = ehi;
      m_lo = elo;
   endtask

   vec_t vt[$];
   logic [63:0] e;
   int bc, dc, dp;

   initial begin
      reset = 1'b1; start = 1'b0; op = '0;
      rs_val = '0; rt_val = '0; d_is_md = 1'b1;
      m_hi = '0; m_lo = '0;
      #12;
      check("reset busy", busy, 0);
      check("reset stall", stall, 0);
      check("reset done", done, 0);
      check("reset hi", hi, 0);
      check("reset lo", lo, 0);
      @(negedge clk);
      reset = 1'b0;
      d_is_md = 1'b0;

      vt.push_back('{3'd0, 32'hFFFFFFFE, 32'd3,
                     32'hFFFFFFFF, 32'hFFFFFFFA, "mult"});
      vt.push_back('{3'd1, 32'hFFFFFFFE, 32'd3,
                     32'h00000002, 32'hFFFFFFFA, "multu"});
      vt.push_back('{3'd2, 32'hFFFFFFF9, 32'd2,
                     32'hFFFFFFFF, 32'hFFFFFFFD, "div"});
      vt.push_back('{3'd3, 32'h1234, 32'd0,
                     32'hFFFFFFFF, 32'hFFFFFFFD, "divu0"});
      vt.push_back('{3'd4, 32'h12345678, 32'd0,
                     32'h12345678, 32'hFFFFFFFD, "mthi"});
      vt.push_back('{3'd5, 32'hCAFEF00D, 32'd0,
                     32'h12345678, 32'hCAFEF00D, "mtlo"});
      vt.push_back('{3'd2, 32'h80000000, 32'hFFFFFFFF,
                     32'h00000000, 32'h80000000, "div_ovf"});
      vt.push_back('{3'd2, 32'd7, 32'hFFFFFFFE,
                     32'h00000001, 32'hFFFFFFFD, "div_pn"});
      vt.push_back('{3'd3, 32'hFFFFFFF9, 32'd2,
                     32'h00000001, 32'h7FFFFFFC, "divu"});
      foreach (vt[i])
         run_op(vt[i].op, vt[i].rs, vt[i].rt,
                vt[i].ehi, vt[i].elo, vt[i].nm);

      // Stall with MFLO waiting in D across a DIV.
      e = ref_md(3'd2, 32'd100, 32'd7, {m_hi, m_lo});
      @(negedge clk);
      d_is_md = 1'b1;
      start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
      #1;
      check("stall issue", stall, 1);
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 1; i <= DC + 1; i++) begin
         @(negedge clk);
         check($sformatf("stall c%0d", i), stall, (i <= DC) ? 1 : 0);
      end
      check("stall mflo lo", lo, e[31:0]);
      check("stall mflo hi", hi, e[63:32]);
      d_is_md = 1'b0;
      m_hi = e[63:32]; m_lo = e[31:0];

      // Start mid-RUN is ignored.
      e = ref_md(3'd0, 32'd1000, 32'hFFFFFFFD, {m_hi, m_lo});
      @(negedge clk);
      start = 1'b1; op = 3'd0; rs_val = 32'd1000; rt_val = 32'hFFFFFFFD;
      @(posedge clk);
      #1;
      start = 1'b0;
      bc = 0; dc = 0; dp = -1;
      for (int i = 1; i <= MC + 3; i++) begin
         @(negedge clk);
         if (i == 2) begin
            start = 1'b1; op = 3'd3;
            rs_val = 32'd99; rt_val = 32'd4;
         end else begin
            start = 1'b0;
         end
         if (busy) bc++;
         if (done) begin dc++; dp = i; end
      end
      check("viol busy_cycles", bc, MC);
      check("viol done_pos", dp, MC);
      check("viol done_count", dc, 1);
      check("viol hi", hi, e[63:32]);
      check("viol lo", lo, e[31:0]);
      m_hi = e[63:32]; m_lo = e[31:0];

      // Reset in the middle of a DIV.
      run_op(3'd4, 32'hAAAA0000, 0, 32'hAAAA0000, m_lo, "pre_hi");
      @(negedge clk);
      start = 1'b1; op = 3'd2; rs_val = 32'd50; rt_val = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst busy", busy, 0);
      check("rst hi", hi, 0);
      check("rst lo", lo, 0);
      check("rst done", done, 0);
      @(negedge clk);
      reset = 1'b0;
      dc = 0; bc = 0;
      for (int i = 0; i < DC + 2; i++) begin
         @(negedge clk);
         if (done) dc++;
         if (busy) bc++;
      end
      check("rst no_done", dc, 0);
      check("rst no_busy", bc, 0);
      check("rst hi_after", hi, 0);
      m_hi = '0; m_lo = '0;

      // Randomized ops against the reference model.
      for (int k = 0; k < 40; k++) begin
         logic [2:0]  ro;
         logic [31:0] ra, rb;
         ro = 3'($urandom_range(0, 5));
         ra = $urandom;
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: rb = 32'($urandom_range(1, 9));
            2: rb = 32'hFFFFFFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
         e = ref_md(ro, ra, rb, {m_hi, m_lo});
         run_op(ro, ra, rb, e[63:32], e[31:0],
                $sformatf("rnd%0d op%0d", k, ro));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
